// File: rtl/fb_stream_vport.sv
// Framebuffer stream to raster video port: pixel FIFO, raster timing
// generator and frame-lock state machine feeding the DVI serializer.
module fb_stream_vport #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic [30:0] iFB_DATA,
  input  logic        iFB_DV,
  input  logic        iFB_START,
  output logic        oFB_READY,
  input  logic        iCLR_ERR,
  output logic [7:0]  oRED,
  output logic [7:0]  oGRN,
  output logic [7:0]  oBLU,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic        oLOCKED,
  output logic        oUNDERFLOW
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic POL = (SYNC_POL != 0);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);

  localparam logic [1:0] SEEK   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] RESYNC = 2'd3;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    state;
  logic [1:0]    state_n;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   head;

  logic h_wrap;
  logic active;
  logic origin;
  logic hs_on;
  logic vs_on;
  logic empty;
  logic push;
  logic pop;
  logic flush;
  logic shown;
  logic underrun;
  logic unused_bits;

  assign unused_bits = ^iFB_DATA[30:15];

  assign h_wrap = (hcnt == H_LAST);
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign origin = (hcnt == '0) && (vcnt == '0);
  assign hs_on  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_on  = (vcnt >= VS_BEG) && (vcnt < VS_END);

  assign head  = mem[rd_ptr];
  assign empty = (level == '0);

  assign oFB_READY = iRESETn && ((state == SEEK) || (level < FULL));

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    shown    = 1'b0;
    underrun = 1'b0;
    state_n  = state;
    unique case (state)
      SEEK: begin
        if (iFB_DV && iFB_START) begin
          push    = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        push = iFB_DV && oFB_READY;
        if (origin) begin
          pop     = 1'b1;
          shown   = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        push = iFB_DV && oFB_READY;
        if (active) begin
          // frame start must coincide exactly with the raster origin
          if (empty) begin
            underrun = 1'b1;
            state_n  = RESYNC;
          end else if (head[15] != origin) begin
            state_n = RESYNC;
          end else begin
            pop   = 1'b1;
            shown = 1'b1;
          end
        end
      end
      RESYNC: begin
        flush   = 1'b1;
        state_n = SEEK;
      end
      default: state_n = SEEK;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (push) begin
      mem[wr_ptr] <= {iFB_START, iFB_DATA[14:0]};
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      hcnt       <= '0;
      vcnt       <= '0;
      state      <= SEEK;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      oRED       <= 8'd0;
      oGRN       <= 8'd0;
      oBLU       <= 8'd0;
      oDE        <= 1'b0;
      oHS        <= ~POL;
      oVS        <= ~POL;
      oLOCKED    <= 1'b0;
      oUNDERFLOW <= 1'b0;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) begin
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end
      state   <= state_n;
      oLOCKED <= (state_n == RUN);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + LW'(push) - LW'(pop);
      end

      oDE <= active;
      oHS <= hs_on ? POL : ~POL;
      oVS <= vs_on ? POL : ~POL;
      oRED <= shown ? {head[14:10], head[14:12]} : 8'd0;
      oGRN <= shown ? {head[9:5], head[9:7]} : 8'd0;
      oBLU <= shown ? {head[4:0], head[4:2]} : 8'd0;

      if (underrun) begin
        oUNDERFLOW <= 1'b1;
      end else if (iCLR_ERR) begin
        oUNDERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_stream_vport.sv
// Directed bench for fb_stream_vport: raster timing table plus
// lock, backpressure, underrun, misplaced-start and reset sequences.
module tb_fb_stream_vport;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HSY = 3;
  localparam int HB = 3;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VSY = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;

  logic        iCLK = 1'b0;
  logic        iRESETn = 1'b1;
  logic [30:0] iFB_DATA = '0;
  logic        iFB_DV = 1'b0;
  logic        iFB_START = 1'b0;
  logic        iCLR_ERR = 1'b0;
  logic        oFB_READY;
  logic [7:0]  oRED;
  logic [7:0]  oGRN;
  logic [7:0]  oBLU;
  logic        oHS;
  logic        oVS;
  logic        oDE;
  logic        oLOCKED;
  logic        oUNDERFLOW;
  logic [23:0] rgb;

  fb_stream_vport #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(0), .FIFO_DEPTH(16)
  ) dut (
    .iCLK(iCLK), .iRESETn(iRESETn),
    .iFB_DATA(iFB_DATA), .iFB_DV(iFB_DV), .iFB_START(iFB_START),
    .oFB_READY(oFB_READY), .iCLR_ERR(iCLR_ERR),
    .oRED(oRED), .oGRN(oGRN), .oBLU(oBLU),
    .oHS(oHS), .oVS(oVS), .oDE(oDE),
    .oLOCKED(oLOCKED), .oUNDERFLOW(oUNDERFLOW)
  );

  assign rgb = {oRED, oGRN, oBLU};

  always #5 iCLK = ~iCLK;

  typedef struct {
    int         p;
    logic [2:0] tim;
  } tvec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pos = -1;
  int acc = 0;
  bit tchk = 1'b0;
  logic [15:0] src_q[$];
  tvec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @pos %0d: got %0h, want %0h", name, pos, act, exp);
    end
  endtask

  function automatic logic [23:0] rgb8(input logic [14:0] w);
    return {w[14:10], w[14:12], w[9:5], w[9:7], w[4:0], w[4:2]};
  endfunction

  function automatic logic [2:0] exp_tim(input int p);
    int h;
    int v;
    logic de;
    logic hs;
    logic vs;
    h = p % HT;
    v = (p / HT) % VT;
    de = (h < HA) && (v < VA);
    hs = !((h >= HA + HF) && (h < HA + HF + HSY));
    vs = !((v >= VA + VF) && (v < VA + VF + VSY));
    return {de, hs, vs};
  endfunction

  function automatic logic [14:0] t3w(input int p);
    logic [4:0] a;
    a = 5'(p);
    return {a, ~a, a ^ 5'd21};
  endfunction

  // one clock: check raster outputs, then present the next stream word
  task automatic tick();
    @(negedge iCLK);
    pos = cyc;
    cyc++;
    if (tchk) begin
      chk("timing", 32'({oDE, oHS, oVS}), 32'(exp_tim(pos)));
      if (!oDE || !oLOCKED) chk("black", 32'(rgb), 32'd0);
    end
    if (src_q.size() > 0) begin
      iFB_DV = 1'b1;
      iFB_START = src_q[0][15];
      iFB_DATA = {16'hA5A5, src_q[0][14:0]};
      if (oFB_READY) begin
        void'(src_q.pop_front());
        acc++;
      end
    end else begin
      iFB_DV = 1'b0;
      iFB_START = 1'b0;
    end
  endtask

  task automatic do_reset();
    tchk = 1'b0;
    src_q.delete();
    iFB_DV = 1'b0;
    iFB_START = 1'b0;
    iCLR_ERR = 1'b0;
    @(negedge iCLK);
    #1 iRESETn = 1'b0;
    repeat (2) @(negedge iCLK);
    iRESETn = 1'b1;
    cyc = 0;
    pos = -1;
    acc = 0;
    tchk = 1'b1;
  endtask

  task automatic wait_lock(input string name, input int limit);
    int n;
    n = 0;
    while (!oLOCKED && n < limit) begin
      tick();
      n++;
    end
    chk(name, 32'(oLOCKED), 32'd1);
  endtask

  task automatic wait_de(input string name, input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!oDE && n < limit);
    chk(name, 32'(oDE), 32'd1);
  endtask

  task automatic push_red_frame();
    src_q.push_back({1'b1, 15'h7C00});
    for (int i = 1; i < 32; i++) src_q.push_back({1'b0, 15'h03E0});
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_rgb"}, 32'(rgb), 32'd0);
    chk({name, "_sync"}, 32'({oDE, oHS, oVS}), 32'b011);
    chk({name, "_ready"}, 32'(oFB_READY), 32'd0);
    chk({name, "_flags"}, 32'({oLOCKED, oUNDERFLOW}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int de_n;
    int hs_n;
    int vs_n;
    int got;
    int n;

    tv[0]  = '{0, 3'b111};
    tv[1]  = '{7, 3'b111};
    tv[2]  = '{8, 3'b011};
    tv[3]  = '{9, 3'b011};
    tv[4]  = '{10, 3'b001};
    tv[5]  = '{12, 3'b001};
    tv[6]  = '{13, 3'b011};
    tv[7]  = '{15, 3'b011};
    tv[8]  = '{16, 3'b111};
    tv[9]  = '{55, 3'b111};
    tv[10] = '{64, 3'b011};
    tv[11] = '{80, 3'b010};
    tv[12] = '{90, 3'b000};
    tv[13] = '{111, 3'b010};
    tv[14] = '{112, 3'b011};
    tv[15] = '{128, 3'b111};

    // 1: reset values and free-running timing
    #3 iRESETn = 1'b0;
    #4 chk_reset_vals("t1_rst");
    repeat (2) @(negedge iCLK);
    chk_reset_vals("t1_rst_clk");
    iRESETn = 1'b1;
    cyc = 0;
    pos = -1;
    tchk = 1'b1;
    de_n = 0;
    hs_n = 0;
    vs_n = 0;
    foreach (tv[i]) begin
      while (pos < tv[i].p) begin
        tick();
        if (pos < 128) begin
          de_n += int'(oDE);
          hs_n += int'(!oHS);
          vs_n += int'(!oVS);
        end
      end
      chk("t1_vec", 32'({oDE, oHS, oVS}), 32'(tv[i].tim));
    end
    chk("t1_de_cnt", 32'(de_n), 32'd32);
    chk("t1_hs_cnt", 32'(hs_n), 32'd24);
    chk("t1_vs_cnt", 32'(vs_n), 32'd32);
    chk("t1_idle", 32'({oFB_READY, oLOCKED}), 32'b10);

    // 2: lock after dropped words
    do_reset();
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 15'h001F});
    push_red_frame();
    wait_lock("t2_lock", 300);
    chk("t2_origin", 32'(pos % 128), 32'd0);
    chk("t2_pix0", 32'(rgb), 32'hFF0000);
    chk("t2_de0", 32'(oDE), 32'd1);
    got = 0;
    n = 0;
    while (got < 31 && n < 200) begin
      tick();
      n++;
      if (oDE) begin
        chk("t2_pix", 32'(rgb), 32'h00FF00);
        got++;
      end
    end
    chk("t2_count", 32'(got), 32'd31);

    // 3: backpressure in FILL, order preserved
    do_reset();
    for (int p = 0; p < 32; p++) src_q.push_back({p == 0, t3w(p)});
    n = 0;
    do begin
      tick();
      n++;
    end while (oFB_READY && n < 100);
    chk("t3_fill_cnt", 32'(acc), 32'd16);
    chk("t3_fill_lock", 32'(oLOCKED), 32'd0);
    while (pos < 127) tick();
    chk("t3_ready_127", 32'(oFB_READY), 32'd0);
    tick();
    chk("t3_ready_128", 32'(oFB_READY), 32'd1);
    chk("t3_lock_128", 32'(oLOCKED), 32'd1);
    chk("t3_pix0", 32'(rgb), 32'(rgb8(t3w(0))));
    got = 1;
    n = 0;
    while (got < 32 && n < 200) begin
      tick();
      n++;
      if (oDE) begin
        chk("t3_order", 32'(rgb), 32'(rgb8(t3w(got))));
        got++;
      end
    end
    chk("t3_count", 32'(got), 32'd32);
    chk("t3_accepted", 32'(acc), 32'd32);

    // 4: underrun after 10 pixels, clear, relock
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back({i == 0, 15'(i + 1)});
    wait_lock("t4_lock", 300);
    chk("t4_origin", 32'(pos), 32'd128);
    chk("t4_pix0", 32'(rgb), 32'(rgb8(15'd1)));
    for (int k = 1; k <= 10; k++) begin
      wait_de("t4_de", 20);
      if (k < 10) chk("t4_pix", 32'(rgb), 32'(rgb8(15'(k + 1))));
    end
    chk("t4_pos11", 32'(pos), 32'd146);
    chk("t4_black", 32'(rgb), 32'd0);
    chk("t4_uf_set", 32'(oUNDERFLOW), 32'd1);
    tick();
    chk("t4_unlock", 32'(oLOCKED), 32'd0);
    chk("t4_uf_hold", 32'(oUNDERFLOW), 32'd1);
    iCLR_ERR = 1'b1;
    tick();
    iCLR_ERR = 1'b0;
    chk("t4_uf_clr", 32'(oUNDERFLOW), 32'd0);
    push_red_frame();
    wait_lock("t4_relock", 300);
    chk("t4_relock_pos", 32'(pos), 32'd256);
    chk("t4_relock_pix", 32'(rgb), 32'hFF0000);

    // 5: misplaced start bit on pixel 5
    do_reset();
    for (int i = 0; i < 32; i++) src_q.push_back({(i == 0) || (i == 5), 15'h7FFF});
    wait_lock("t5_lock", 300);
    chk("t5_origin", 32'(pos), 32'd128);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk("t5_white", 32'(rgb), 32'hFFFFFF);
    end
    tick();
    chk("t5_bad_pix", 32'({oDE, rgb}), 32'h1000000);
    chk("t5_unlock", 32'(oLOCKED), 32'd0);
    tick();
    chk("t5_seek", 32'({oLOCKED, oFB_READY}), 32'b01);
    n = 0;
    while (src_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_drain", 32'(src_q.size()), 32'd0);
    push_red_frame();
    wait_lock("t5_relock", 300);
    chk("t5_relock_pos", 32'(pos), 32'd256);
    chk("t5_relock_pix", 32'(rgb), 32'hFF0000);
    chk("t5_uf", 32'(oUNDERFLOW), 32'd0);

    // 6: asynchronous reset during active line 2 with 7 words buffered
    do_reset();
    for (int i = 0; i < 26; i++) src_q.push_back({i == 0, 15'h7FFF});
    wait_lock("t6_lock", 300);
    while (pos < 162) tick();
    chk("t6_pre", 32'({oDE, rgb}), 32'h1FFFFFF);
    #2 iRESETn = 1'b0;
    #1 chk_reset_vals("t6_async");
    tchk = 1'b0;
    src_q.delete();
    iFB_DV = 1'b0;
    iFB_START = 1'b0;
    repeat (2) @(negedge iCLK);
    iRESETn = 1'b1;
    cyc = 0;
    pos = -1;
    tchk = 1'b1;
    tick();
    chk("t6_seek", 32'({oFB_READY, oLOCKED}), 32'b10);
    push_red_frame();
    wait_lock("t6_relock", 300);
    chk("t6_relock_pos", 32'(pos), 32'd128);
    chk("t6_relock_pix", 32'(rgb), 32'hFF0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
